// File: rtl/trivium_pkg.sv
// trivium_pkg: shared constants, FSM state type and helper functions for the
// Trivium byte-stream blocks.
//   - State vector layout: s[k-1] holds Trivium bit s_k (s1..s288).
//   - trivium_load(): builds the initial state from an 80-bit key and IV.
//   - trivium_round(): one Trivium round; returns {z, next_state}.
package trivium_pkg;

    localparam int STATE_W = 288;
    localparam int KEY_W   = 80;
    localparam int IV_W    = 80;
    localparam int KS_W    = 8;

    // Default warm-up length in rounds. It must be a multiple of 8.
    localparam int DEF_INIT_ROUNDS = 1152;

    // Register boundaries (1-based, last bit of each register)
    localparam int R1_END  = 93;
    localparam int R2_END  = 177;
    localparam int R3_END  = 288;
    localparam int IV_BASE = 94;

    // Tap indices (1-based, as in the Trivium description)
    localparam int TAP_T1_A     = 66;
    localparam int TAP_T1_B     = 93;
    localparam int TAP_T1_AND_A = 91;
    localparam int TAP_T1_AND_B = 92;
    localparam int TAP_T1_FB    = 171;
    localparam int TAP_T2_A     = 162;
    localparam int TAP_T2_B     = 177;
    localparam int TAP_T2_AND_A = 175;
    localparam int TAP_T2_AND_B = 176;
    localparam int TAP_T2_FB    = 264;
    localparam int TAP_T3_A     = 243;
    localparam int TAP_T3_B     = 288;
    localparam int TAP_T3_AND_A = 286;
    localparam int TAP_T3_AND_B = 287;
    localparam int TAP_T3_FB    = 69;

    typedef enum logic [1:0] {
        IDLE,
        WARMUP,
        RUN
    } fsm_state_t;

    // Key/IV are given MSB-first (key[79] is K1), so both are bit-reversed
    // into the state vector.
    function automatic logic [STATE_W-1:0] trivium_load(
        input logic [KEY_W-1:0] key,
        input logic [IV_W-1:0]  iv
    );
        logic [STATE_W-1:0] s;
        s = '0;
        for (int k = 0; k < KEY_W; k++) begin
            s[k] = key[KEY_W-1-k];
        end
        for (int k = 0; k < IV_W; k++) begin
            s[IV_BASE-1+k] = iv[IV_W-1-k];
        end
        s[STATE_W-1 -: 3] = 3'b111;
        return s;
    endfunction

    // One round: bit STATE_W of the result is the keystream bit z, the
    // lower STATE_W bits are the shifted state.
    function automatic logic [STATE_W:0] trivium_round(input logic [STATE_W-1:0] s);
        logic t1, t2, t3, z;
        t1 = s[TAP_T1_A-1] ^ s[TAP_T1_B-1];
        t2 = s[TAP_T2_A-1] ^ s[TAP_T2_B-1];
        t3 = s[TAP_T3_A-1] ^ s[TAP_T3_B-1];
        z  = t1 ^ t2 ^ t3;
        t1 = t1 ^ (s[TAP_T1_AND_A-1] & s[TAP_T1_AND_B-1]) ^ s[TAP_T1_FB-1];
        t2 = t2 ^ (s[TAP_T2_AND_A-1] & s[TAP_T2_AND_B-1]) ^ s[TAP_T2_FB-1];
        t3 = t3 ^ (s[TAP_T3_AND_A-1] & s[TAP_T3_AND_B-1]) ^ s[TAP_T3_FB-1];
        // Each register shifts toward its high end; feedback enters at the
        // low end (t3 -> s1, t1 -> s94, t2 -> s178).
        return {z,
                s[R3_END-2:R2_END], t2,
                s[R2_END-2:R1_END], t1,
                s[R1_END-2:0],      t3};
    endfunction

endpackage

// File: rtl/trivium_decrypt_stream_if.sv
// trivium_decrypt_stream_if: key load, ciphertext input stream, plaintext
// output stream and status of the Trivium decryptor.
//   key_load/key/iv : load strobe and key material (sampled on strobe only)
//   in_valid/in_ready/in_data    : ciphertext byte stream into the decryptor
//   out_valid/out_ready/out_data : plaintext byte stream out of the decryptor
//   keyed : warm-up finished, stream running
// master = the side driving key material, ciphertext and out_ready;
// slave  = the decryptor.
interface trivium_decrypt_stream_if;
    import trivium_pkg::*;

    logic             key_load;
    logic [KEY_W-1:0] key;
    logic [IV_W-1:0]  iv;
    logic             in_valid;
    logic             in_ready;
    logic [7:0]       in_data;
    logic             out_valid;
    logic             out_ready;
    logic [7:0]       out_data;
    logic             keyed;

    modport master (
        output key_load, key, iv, in_valid, in_data, out_ready,
        input  in_ready, out_valid, out_data, keyed
    );

    modport slave (
        input  key_load, key, iv, in_valid, in_data, out_ready,
        output in_ready, out_valid, out_data, keyed
    );

endinterface

// File: rtl/trivium_step8.sv
// trivium_step8: purely combinational block applying 8 chained Trivium
// rounds. Shared with the keystream generator side.
//   s_in  : current 288-bit state (s[k-1] = s_k)
//   s_out : state after 8 rounds
//   ks    : keystream byte; first generated bit in ks[0]
module trivium_step8
    import trivium_pkg::*;
(
    input  logic [STATE_W-1:0] s_in,
    output logic [STATE_W-1:0] s_out,
    output logic [KS_W-1:0]    ks
);

    logic [STATE_W-1:0] st;
    logic [STATE_W:0]   rnd;

    always_comb begin
        st  = s_in;
        ks  = '0;
        rnd = '0;
        for (int i = 0; i < KS_W; i++) begin
            rnd   = trivium_round(st);
            ks[i] = rnd[STATE_W];
            st    = rnd[STATE_W-1:0];
        end
        s_out = st;
    end

endmodule

// File: rtl/trivium_decrypt_stream.sv
// trivium_decrypt_stream: byte-stream Trivium decryptor.
// After key_load the state is loaded and warmed up for INIT_ROUNDS rounds
// (8 per clock); afterwards every accepted ciphertext byte is XORed with the
// next 8 keystream bits and presented on the plaintext stream one clock later.
//   clk  : clock
//   rst  : asynchronous, active-low reset
//   bus  : key load, ciphertext in, plaintext out, keyed status
module trivium_decrypt_stream
    import trivium_pkg::*;
#(
    parameter int INIT_ROUNDS   = DEF_INIT_ROUNDS,
    parameter int STEPS_PER_CLK = 8
) (
    input logic                    clk,
    input logic                    rst,
    trivium_decrypt_stream_if.slave bus
);

    localparam int WARM_CLKS = INIT_ROUNDS / STEPS_PER_CLK;
    localparam int CNT_W     = (WARM_CLKS > 1) ? $clog2(WARM_CLKS) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WARM_CLKS - 1);

    fsm_state_t         state_reg, state_next;
    logic [CNT_W-1:0]   cnt_reg;
    logic [STATE_W-1:0] s_reg;
    logic [STATE_W-1:0] s_stepped;
    logic [KS_W-1:0]    ks_byte;
    logic               out_valid_reg;
    logic [7:0]         out_data_reg;
    logic               in_ready_next;
    logic               accept;

    trivium_step8 u_step8 (
        .s_in  (s_reg),
        .s_out (s_stepped),
        .ks    (ks_byte)
    );

    // State register
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_reg <= IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    // Next state and ready
    always_comb begin
        state_next    = state_reg;
        in_ready_next = 1'b0;
        case (state_reg)
            IDLE: begin
                state_next = IDLE;
            end
            WARMUP: begin
                if (cnt_reg == CNT_LAST) begin
                    state_next = RUN;
                end
            end
            RUN: begin
                // Ready only looks at the output slot, never at in_valid.
                in_ready_next = !out_valid_reg || bus.out_ready;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
        // A reload restarts warm-up from any state.
        if (bus.key_load) begin
            state_next = WARMUP;
        end
    end

    // key_load wins over a byte handed over in the same cycle; that byte is lost.
    assign accept = in_ready_next && bus.in_valid && !bus.key_load;

    // Cipher state, warm-up counter and output register
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt_reg       <= '0;
            s_reg         <= '0;
            out_valid_reg <= 1'b0;
            out_data_reg  <= 8'h00;
        end else if (bus.key_load) begin
            s_reg         <= trivium_load(bus.key, bus.iv);
            cnt_reg       <= '0;
            out_valid_reg <= 1'b0;
        end else if (state_reg == WARMUP) begin
            s_reg   <= s_stepped;
            cnt_reg <= (cnt_reg == CNT_LAST) ? '0 : cnt_reg + CNT_W'(1);
        end else if (accept) begin
            // Keystream only advances when a ciphertext byte is consumed.
            s_reg         <= s_stepped;
            out_data_reg  <= bus.in_data ^ ks_byte;
            out_valid_reg <= 1'b1;
        end else if (bus.out_ready) begin
            out_valid_reg <= 1'b0;
        end
    end

    assign bus.in_ready  = in_ready_next;
    assign bus.out_valid = out_valid_reg;
    assign bus.out_data  = out_data_reg;
    assign bus.keyed     = (state_reg == RUN);

endmodule

// File: tb/tb_trivium_decrypt_stream.sv
module tb_trivium_decrypt_stream;

    localparam int WARM = 144;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    trivium_decrypt_stream_if bus ();

    trivium_decrypt_stream dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int total = 0;
    int bad   = 0;

    // Behavioural model state (written only by the driver)
    logic [288:1] m_st;
    int           m_warm;
    bit           m_keyed;
    bit           m_valid;
    bit           m_zero;
    logic [7:0]   m_data;
    bit           chk_en = 1'b0;
    bit           last_acc;

    // ---------------- bit-serial reference Trivium ----------------
    function automatic logic [288:1] ref_load(input logic [79:0] k, input logic [79:0] v);
        logic [288:1] s;
        s = '0;
        for (int i = 1; i <= 80; i++) begin
            s[i]      = k[80-i];
            s[93 + i] = v[80-i];
        end
        s[286] = 1'b1;
        s[287] = 1'b1;
        s[288] = 1'b1;
        return s;
    endfunction

    function automatic logic ref_round(inout logic [288:1] s);
        logic t1, t2, t3, z;
        t1 = s[66] ^ s[93];
        t2 = s[162] ^ s[177];
        t3 = s[243] ^ s[288];
        z  = t1 ^ t2 ^ t3;
        t1 = t1 ^ (s[91] & s[92]) ^ s[171];
        t2 = t2 ^ (s[175] & s[176]) ^ s[264];
        t3 = t3 ^ (s[286] & s[287]) ^ s[69];
        for (int k = 93; k >= 2; k--) s[k] = s[k-1];
        s[1] = t3;
        for (int k = 177; k >= 95; k--) s[k] = s[k-1];
        s[94] = t1;
        for (int k = 288; k >= 179; k--) s[k] = s[k-1];
        s[178] = t2;
        return z;
    endfunction

    function automatic logic [7:0] ref_byte(inout logic [288:1] s);
        logic [7:0] b;
        for (int i = 0; i < 8; i++) b[i] = ref_round(s);
        return b;
    endfunction

    function automatic logic [7:0] ref_peek(input logic [288:1] s);
        logic [288:1] c;
        c = s;
        return ref_byte(c);
    endfunction

    // ---------------- compare process ----------------
    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at t=%0t", name, got, exp, $time);
        end
    endtask

    initial begin : compare
        logic [288:1] p;
        logic [7:0]   b;
        // Hand-derived first keystream bytes (no warm-up) that pin the model:
        // all-zero key/IV gives z=1 for rounds 1..3 from the s286..s288 ones.
        p = ref_load(80'h0, 80'h0);
        b = ref_byte(p);
        check("pin_zero_byte0", {24'h0, b}, 32'h07);
        b = ref_byte(p);
        check("pin_zero_byte1", {24'h0, b}, 32'h00);
        // IV80 lands in s173 and reaches tap s177 on round 5 (bit 4).
        p = ref_load(80'h0, 80'h1);
        b = ref_byte(p);
        check("pin_iv80_byte0", {24'h0, b}, 32'h17);
        // K80 lands in s80 and reaches tap s93 on round 14 (bit 5 of byte 1).
        p = ref_load(80'h1, 80'h0);
        b = ref_byte(p);
        check("pin_k80_byte0", {24'h0, b}, 32'h07);
        b = ref_byte(p);
        check("pin_k80_byte1", {24'h0, b}, 32'h20);

        forever begin
            @(negedge clk);
            if (chk_en) begin
                check("keyed", {31'h0, bus.keyed}, {31'h0, m_keyed});
                check("out_valid", {31'h0, bus.out_valid}, {31'h0, m_valid});
                check("in_ready", {31'h0, bus.in_ready},
                      {31'h0, (m_keyed && (!m_valid || bus.out_ready))});
                if (m_valid || m_zero)
                    check("out_data", {24'h0, bus.out_data}, {24'h0, m_data});
            end
        end
    end

    // ---------------- driver + model update ----------------
    task automatic tick();
        logic        acc;
        logic [7:0]  ks;
        logic [95:0] r;
        if (!bus.key_load) begin
            // Key/IV wander when not loading; the DUT must ignore them.
            r = {$urandom(), $urandom(), $urandom()};
            bus.key = r[79:0];
            r = {$urandom(), $urandom(), $urandom()};
            bus.iv = r[79:0];
        end
        acc = rst && m_keyed && bus.in_valid && (!m_valid || bus.out_ready) && !bus.key_load;
        last_acc = acc;
        @(posedge clk);
        if (rst) begin
            if (bus.key_load) begin
                m_st    = ref_load(bus.key, bus.iv);
                m_warm  = WARM;
                m_keyed = 1'b0;
                m_valid = 1'b0;
            end else if (m_warm > 0) begin
                void'(ref_byte(m_st));
                m_warm--;
                if (m_warm == 0) m_keyed = 1'b1;
            end else if (acc) begin
                ks      = ref_byte(m_st);
                m_data  = bus.in_data ^ ks;
                m_valid = 1'b1;
                m_zero  = 1'b0;
                $display("txn t=%0t ct=%02h ks=%02h pt=%02h", $time, bus.in_data, ks, m_data);
            end else if (bus.out_ready) begin
                m_valid = 1'b0;
            end
        end
        #2;
    endtask

    task automatic do_load(input logic [79:0] k, input logic [79:0] v);
        bus.key      = k;
        bus.iv       = v;
        bus.key_load = 1'b1;
        tick();
        bus.key_load = 1'b0;
    endtask

    task automatic rand_stream();
        bus.in_valid  = ($urandom_range(0, 3) != 0);
        bus.in_data   = 8'($urandom());
        bus.out_ready = ($urandom_range(0, 3) != 0);
    endtask

    task automatic warm_until_keyed();
        for (int i = 0; i < WARM + 10 && !m_keyed; i++) begin
            rand_stream();
            tick();
        end
    endtask

    task automatic model_reset();
        m_keyed = 1'b0;
        m_valid = 1'b0;
        m_data  = 8'h00;
        m_zero  = 1'b1;
        m_warm  = 0;
    endtask

    initial begin : driver
        int idx;
        bus.key_load  = 1'b0;
        bus.key       = '0;
        bus.iv        = '0;
        bus.in_valid  = 1'b0;
        bus.in_data   = 8'h00;
        bus.out_ready = 1'b0;
        m_st          = '0;
        last_acc      = 1'b0;
        model_reset();
        chk_en = 1'b1;

        // Reset, then idle with random traffic: nothing may be accepted.
        repeat (3) tick();
        rst = 1'b1;
        repeat (6) begin rand_stream(); tick(); end

        // Load the reference key/IV and warm up with junk on the input.
        do_load(80'h9719CFC92A9FF688F9AA, 80'hECBB76B09AFF71D0D151);
        warm_until_keyed();

        // Golden stream: plaintext 0x00..0x3F, with a 5-clock stall mid-way.
        idx = 0;
        bus.in_valid  = 1'b1;
        bus.out_ready = 1'b1;
        for (int guard = 0; guard < 200 && idx < 64; guard++) begin
            if (idx == 32 && bus.out_ready) begin
                bus.out_ready = 1'b0;
                repeat (5) tick();
                bus.out_ready = 1'b1;
            end
            bus.in_data = 8'(idx) ^ ref_peek(m_st);
            tick();
            if (last_acc) idx++;
        end

        // Random traffic with random backpressure.
        repeat (200) begin rand_stream(); tick(); end

        // Rekey while a byte is pending and another is being offered.
        bus.in_valid  = 1'b1;
        bus.out_ready = 1'b0;
        for (int i = 0; i < 4 && !m_valid; i++) tick();
        bus.out_ready = 1'b1;
        do_load(80'h0123456789ABCDEF0123, 80'hFEDCBA98765432100F0F);
        warm_until_keyed();
        repeat (60) begin rand_stream(); tick(); end

        // Zero ciphertext exposes the raw keystream bytes.
        bus.in_valid  = 1'b1;
        bus.in_data   = 8'h00;
        bus.out_ready = 1'b1;
        repeat (24) tick();

        // Asynchronous reset mid-stream, between clock edges.
        rst = 1'b0;
        model_reset();
        repeat (2) tick();
        rst = 1'b1;
        repeat (5) begin rand_stream(); tick(); end

        // Recovery after reset.
        do_load(80'hA5A5A5A5A5A5A5A5A5A5, 80'h5A5A5A5A5A5A5A5A5A5A);
        warm_until_keyed();
        repeat (30) begin rand_stream(); tick(); end

        @(negedge clk);
        #1;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
